// File: rtl/counter_ctrl_if.sv
// Command/status bundle between a run controller and the logic that drives it.
// The master issues commands and configuration; the slave reports count and status.
interface counter_ctrl_if #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned PRE_W = 8
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             auto_reload;
   logic [CNT_W-1:0] load_val;
   logic [PRE_W-1:0] prescale;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done;
   logic             out;
   logic [1:0]       state;

   modport master (
      output start, stop, pause, auto_reload, load_val, prescale,
      input  cnt, busy, done, out, state
   );

   modport slave (
      input  start, stop, pause, auto_reload, load_val, prescale,
      output cnt, busy, done, out, state
   );
endinterface

// File: rtl/counter_ctrl.sv
// Run controller for a programmable up-counter: start/stop/pause sequencing,
// prescaled ticks, one-shot or auto-reload wrap, done pulse and toggle output.
module counter_ctrl #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned PRE_W = 8
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   counter_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] term_q, term_d;
   logic [PRE_W-1:0] pre_lat_q, pre_lat_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic             done_q, done_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;

   // State and datapath registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         term_q    <= '0;
         pre_lat_q <= '0;
         pre_cnt_q <= '0;
         done_q    <= 1'b0;
         out_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         term_q    <= term_d;
         pre_lat_q <= pre_lat_d;
         pre_cnt_q <= pre_cnt_d;
         done_q    <= done_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state: stop beats start beats pause; a HOLD release steps on the same edge
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      term_d    = term_q;
      pre_lat_d = pre_lat_q;
      pre_cnt_d = pre_cnt_q;
      done_d    = 1'b0;
      out_d     = out_q;

      case (state_q)
         IDLE: begin
            if (bus.stop) begin
               cnt_d = '0;
            end else if (bus.start) begin
               term_d    = bus.load_val;
               pre_lat_d = bus.prescale;
               cnt_d     = '0;
               pre_cnt_d = '0;
               state_d   = RUN;
            end
         end
         RUN, HOLD: begin
            if (bus.stop) begin
               cnt_d     = '0;
               pre_cnt_d = '0;
               state_d   = IDLE;
            end else if (bus.start) begin
               term_d    = bus.load_val;
               pre_lat_d = bus.prescale;
               cnt_d     = '0;
               pre_cnt_d = '0;
               state_d   = RUN;
            end else if (bus.pause) begin
               state_d = HOLD;
            end else begin
               state_d = RUN;
               if (pre_cnt_q == pre_lat_q) begin
                  pre_cnt_d = '0;
                  if (cnt_q == term_q) begin
                     cnt_d  = '0;
                     done_d = 1'b1;
                     out_d  = ~out_q;
                     if (!bus.auto_reload) begin
                        state_d = IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  pre_cnt_d = pre_cnt_q + PRE_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN) || (state_d == HOLD);
   end

   assign bus.cnt   = cnt_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.out   = out_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus randomized traffic
// compared every cycle against an elapsed-time reference model.
module tb_counter_ctrl;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned PRE_W = 8;

   logic clk;
   logic sys_rst_n;

   counter_ctrl_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

   counter_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
      .sys_clk   (clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counting clocks since start, count = elapsed / (pre+1)
   bit m_run, m_hold, m_out, m_done;
   int m_active, m_term, m_pre;

   int lv_g = 0, ps_g = 0;
   bit ar_g = 1'b1;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_run = 0; m_hold = 0; m_out = 0; m_done = 0;
      m_active = 0; m_term = 0; m_pre = 0;
   endfunction

   function automatic void model_edge(input bit s, input bit st, input bit p, input bit ar,
                                      input int lv, input int ps);
      int period;
      m_done = 0;
      if (st) begin
         m_run = 0; m_hold = 0;
      end else if (s) begin
         m_term = lv; m_pre = ps; m_active = 0; m_run = 1; m_hold = 0;
      end else if (m_run && p) begin
         m_hold = 1;
      end else if (m_run) begin
         m_hold = 0;
         m_active++;
         period = (m_term + 1) * (m_pre + 1);
         if (m_active == period) begin
            m_active = 0;
            m_done   = 1;
            m_out    = !m_out;
            if (!ar) m_run = 0;
         end
      end
   endfunction

   task automatic compare_all();
      int exp_cnt, exp_state;
      exp_cnt   = m_run ? (m_active / (m_pre + 1)) : 0;
      exp_state = !m_run ? 0 : (m_hold ? 2 : 1);
      check("state", int'(bus.state), exp_state);
      check("cnt",   int'(bus.cnt),   exp_cnt);
      check("busy",  int'(bus.busy),  int'(m_run));
      check("done",  int'(bus.done),  int'(m_done));
      check("out",   int'(bus.out),   int'(m_out));
   endtask

   task automatic step(input bit s, input bit st, input bit p, input bit ar,
                       input int lv, input int ps);
      bus.start       = s;
      bus.stop        = st;
      bus.pause       = p;
      bus.auto_reload = ar;
      bus.load_val    = CNT_W'(lv);
      bus.prescale    = PRE_W'(ps);
      @(posedge clk);
      model_edge(s, st, p, ar, lv, ps);
      #1;
      compare_all();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, ar_g, lv_g, ps_g);
   endtask

   task automatic start_run(input int lv, input int ps, input bit ar);
      lv_g = lv; ps_g = ps; ar_g = ar;
      step(1, 0, 0, ar, lv, ps);
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock edge
   task automatic do_reset();
      #2;
      bus.start = 0; bus.stop = 0; bus.pause = 0;
      sys_rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      sys_rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  cnt_done, edges, pb;
      bit  s, st, p;
      int  lv, ps;

      sys_rst_n = 1'b0;
      bus.start = 0; bus.stop = 0; bus.pause = 0; bus.auto_reload = 0;
      bus.load_val = '0; bus.prescale = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      sys_rst_n = 1'b1;
      idle_n(3);

      // Full-range auto-reload: two wraps in 32 clocks
      start_run(15, 0, 1);
      cnt_done = 0;
      for (int i = 0; i < 32; i++) begin
         idle_n(1);
         if (bus.done) cnt_done++;
      end
      check("t1_done_count", cnt_done, 2);

      // Prescaled one-shot: wrap 12 edges after start
      start_run(3, 2, 0);
      edges = 0;
      for (int i = 1; i <= 50; i++) begin
         idle_n(1);
         if (bus.done) begin edges = i; break; end
      end
      check("t2_wrap_edge", edges, 12);
      check("t2_busy_after", int'(bus.busy), 0);
      check("t2_cnt_after", int'(bus.cnt), 0);

      // Pause at cnt=6 for 5 clocks delays the wrap by 5
      do_reset();
      start_run(15, 0, 1);
      idle_n(6);
      check("t3_cnt_before_pause", int'(bus.cnt), 6);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 1, lv_g, ps_g);
         check("t3_cnt_held", int'(bus.cnt), 6);
      end
      idle_n(1);
      check("t3_cnt_resume", int'(bus.cnt), 7);
      edges = 12;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) break;
         idle_n(1);
         edges++;
      end
      check("t3_wrap_edge", edges, 21);

      // Stop at cnt=9, then simultaneous start+stop
      idle_n(9);
      check("t4_cnt_before_stop", int'(bus.cnt), 9);
      step(0, 1, 0, 1, lv_g, ps_g);
      check("t4_stop_state", int'(bus.state), 0);
      step(1, 1, 0, 1, 7, 0);
      check("t4_both_state", int'(bus.state), 0);
      check("t4_both_cnt", int'(bus.cnt), 0);

      // Restart with term=2; later load_val changes are ignored
      start_run(15, 0, 1);
      idle_n(4);
      start_run(2, 0, 1);
      check("t5_restart_cnt", int'(bus.cnt), 0);
      lv_g = 9;
      cnt_done = 0;
      for (int i = 0; i < 9; i++) begin
         idle_n(1);
         if (bus.done) cnt_done++;
      end
      check("t5_done_count", cnt_done, 3);

      // Asynchronous reset at cnt=11 with out=1
      do_reset();
      start_run(15, 0, 1);
      idle_n(27);
      check("t6_cnt_pre_reset", int'(bus.cnt), 11);
      check("t6_out_pre_reset", int'(bus.out), 1);
      do_reset();
      idle_n(5);
      check("t6_idle_after", int'(bus.state), 0);

      // Randomized traffic against the model
      pb = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            s  = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 49) == 0);
            if (pb == 0 && $urandom_range(0, 19) == 0) pb = $urandom_range(1, 6);
            p = (pb > 0);
            if (pb > 0) pb--;
            if ($urandom_range(0, 99) == 0) ar_g = !ar_g;
            lv = $urandom_range(0, 15);
            ps = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            step(s, st, p, ar_g, lv, ps);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Run controller for a programmable up-counter. It accepts start/stop/pause commands and applies a latched terminal value and prescaler. It sequences the count in one-shot or auto-reload mode and reports terminal-count events. It sits between control logic or the button/LED front end and the counting datapath. It also provides the toggle-on-wrap output used for LED/wave generation.

Parameters:
CNT_W, 4, count width; the count runs 0..term, and term is at most 2^CNT_W-1.
PRE_W, 8, prescaler width; the count advances once every (prescale+1) clocks.

Ports:
sys_clk  input  1  system clock; all state changes on the rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
start  input  1  level sampled each clock; starts or restarts a run.
stop  input  1  level sampled each clock; aborts the run.
pause  input  1  level; freezes a running count while high.
auto_reload  input  1  1 = periodic, 0 = one-shot; sampled at every wrap.
load_val  input  CNT_W  terminal value; latched on an accepted start.
prescale  input  PRE_W  prescale divisor minus 1; latched on an accepted start.
cnt  output  CNT_W  current count (registered).
busy  output  1  high in RUN or HOLD.
done  output  1  one-cycle pulse at each terminal wrap.
out  output  1  toggles at each terminal wrap.
state  output  2  FSM encoding: IDLE=0, RUN=1, HOLD=2; 3 is never reached.

Behaviour:
- Reset, asynchronous with sys_rst_n=0:
  - state=IDLE; cnt=0, done=0, out=0, busy=0.
  - Internal term=0, pre_lat=0, pre_cnt=0.
  - Reset takes effect immediately, including mid-run.
  - After sys_rst_n rises, the block stays in IDLE until a start.
- Command priority per edge: stop > start > pause.
- IDLE:
  - cnt holds its value.
  - start=1: latch term<=load_val and pre_lat<=prescale; cnt<=0, pre_cnt<=0; go to RUN.
  - stop=1 in IDLE: cnt<=0, no other effect.
- RUN:
  - stop=1: cnt<=0, pre_cnt<=0, go to IDLE; no done, out unchanged.
  - Else start=1: restart; relatch term and pre_lat, cnt<=0, pre_cnt<=0, stay in RUN.
  - Else pause=1: go to HOLD; cnt and pre_cnt frozen; no tick on this edge.
  - Else prescaler step:
    - If pre_cnt==pre_lat: pre_cnt<=0 and a tick occurs.
    - Otherwise pre_cnt<=pre_cnt+1.
  - On a tick:
    - cnt!=term: cnt<=cnt+1.
    - cnt==term (wrap): done<=1 for the following cycle, out<=~out, cnt<=0.
    - Then auto_reload=1 stays in RUN; auto_reload=0 goes to IDLE.
- HOLD:
  - stop behaves as in RUN; start behaves as a restart into RUN.
  - pause=0: return to RUN; counting resumes on the next edge with no tick lost or duplicated.
- done: registered and high exactly one cycle per wrap; low in all other cycles.
- busy: (state==RUN)||(state==HOLD), registered with the state.
- Timing:
  - Start accepted at edge k: the first increment is at edge k+1+pre_lat.
  - The wrap occurs at edge k+(term+1)*(pre_lat+1).
- Boundaries:
  - term=0: every tick is a wrap.
  - pre_lat=0: a tick every clock.
  - term=2^CNT_W-1: the full range is used; there is no arithmetic overflow, because the wrap goes to 0 explicitly.
  - load_val and prescale changes during a run have no effect until the next accepted start.
  - start and stop together: stop wins, giving IDLE with cnt=0.

Test Plan:
1. Auto-reload, full range. Reset, then start for 1 clock with load_val=15, prescale=0, auto_reload=1 → cnt steps 0..15 one per clock; done pulses every 16 clocks; out period is 32 clocks; busy stays 1.
2. Prescaled one-shot. Start with load_val=3, prescale=2, auto_reload=0 → cnt increments every 3 clocks; the wrap and single done pulse occur 12 clocks after the start edge; the block then returns to IDLE with cnt=0 and busy=0; out toggles once.
3. Pause mid-run. Config as test 1 with pause=1 for 5 clocks at cnt=6 → state=HOLD and cnt stays 6 for 5 clocks; after release cnt resumes at 7; the wrap is delayed by exactly 5 clocks.
4. Stop and start/stop priority. stop at cnt=9 → IDLE, cnt=0, no done, out unchanged. start and stop asserted together → state stays IDLE, cnt=0.
5. Restart and latching. Mid-run start with load_val=2 → cnt=0 on the next edge; a wrap occurs every 3 ticks. A load_val change without start → period unchanged.
6. Reset mid-operation. Assert sys_rst_n=0 asynchronously at cnt=11 with out=1 → all outputs go to 0 immediately, without waiting for a clock edge; after release the block stays in IDLE until a start.
